// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one instruction-memory request at a time,
// holds the returned word for decode and handles redirects and stale responses.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  take_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  misalign_o,
    output logic [1:0]            state_o
);

    // Handshakes: a memory request transfers on a cycle with imem_req_o && imem_gnt_i;
    // an instruction transfers on a cycle with instr_valid_o && instr_ready_i, and
    // instr_o/pc_o are held stable while valid and not yet accepted.

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] req_addr_q;
    logic                  req_fire;
    logic                  capture;

    assign imem_req_o  = rst_ni && (state_q == ST_REQ) && !stall_i && !instr_valid_o && !take_i;
    assign imem_addr_o = pc_q;
    assign req_fire    = imem_req_o && imem_gnt_i;
    assign capture     = (state_q == ST_WAIT) && imem_rvalid_i && !take_i;
    assign state_o     = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (take_i)             state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
                else if (imem_rvalid_i) state_d = ST_REQ;
            end
            ST_DROP: begin
                // A redirect here only moves pc_q; the stale response is still owed.
                if (imem_rvalid_i) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            misalign_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_o <= take_i && (target_i[1:0] != 2'b00);

            if (take_i) begin
                pc_q <= {target_i[DATA_WIDTH-1:2], 2'b00};
            end else if (req_fire) begin
                pc_q       <= pc_q + DATA_WIDTH'(4);
                req_addr_q <= pc_q;
            end

            if (take_i) begin
                instr_valid_o <= 1'b0;
            end else if (capture) begin
                instr_valid_o <= 1'b1;
                instr_o       <= imem_rdata_i;
                pc_o          <= req_addr_q;
            end else if (instr_valid_o && instr_ready_i) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule
